// File: rtl/refclk_mux_sel_ctrl_pkg.sv
// Shared types and constants for the reference clock mux select controller.
// The counter-width helper sizes the one down-counter shared by the settle and holdoff phases.
package refclk_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    HOLDOFF = 2'd2
  } ctrlState_t;

  localparam logic SEL_CLOCK_A = 1'b0;
  localparam logic SEL_CLOCK_B = 1'b1;

  // The counter must hold the larger load value; a floor of 2 keeps the width at least 1 bit.
  function automatic int ctrlCntWidth(input int settleCycles, input int holdoffCycles);
    int maxVal;
    maxVal = settleCycles;
    if (holdoffCycles > maxVal) begin
      maxVal = holdoffCycles;
    end else begin
      maxVal = maxVal;
    end
    if (maxVal < 2) begin
      maxVal = 2;
    end else begin
      maxVal = maxVal;
    end
    return $clog2(maxVal);
  endfunction

endpackage

// File: rtl/refclk_mux_sel_ctrl.sv
// Select controller in front of the glitchless reference clock mux: accepts switch requests,
// holds sel stable while the mux hands off, then commits and enforces a holdoff before the next request.
module refclk_mux_sel_ctrl
  import refclk_ctrl_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 16,
  parameter int HOLDOFF_CYCLES = 8,
  parameter int COUNT_W        = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_sel,
  output logic               sel,
  output logic               cur_sel,
  output logic               busy,
  output logic               done,
  output logic [COUNT_W-1:0] switch_count
);

  localparam int CW              = ctrlCntWidth(SETTLE_CYCLES, HOLDOFF_CYCLES);
  localparam int HOLDOFF_LOAD_I  = (HOLDOFF_CYCLES > 0) ? HOLDOFF_CYCLES - 1 : 0;
  localparam logic [CW-1:0] SETTLE_LOAD  = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] HOLDOFF_LOAD = CW'(HOLDOFF_LOAD_I);
  localparam logic [COUNT_W-1:0] COUNT_MAX = {COUNT_W{1'b1}};

  ctrlState_t    stateR;
  logic [CW-1:0] cntR;

  // Ready and busy are pure state decodes, so req_valid never reaches req_ready.
  assign req_ready = (stateR == IDLE);
  assign busy      = (stateR != IDLE);

  // Control FSM: request acceptance, settle countdown, commit and holdoff.
  always_ff @(posedge clock) begin
    if (reset) begin
      stateR       <= IDLE;
      cntR         <= '0;
      sel          <= SEL_CLOCK_A;
      cur_sel      <= SEL_CLOCK_A;
      done         <= 1'b0;
      switch_count <= '0;
    end else begin
      done <= 1'b0;
      case (stateR)
        IDLE: begin
          if (req_valid) begin
            if (req_sel == cur_sel) begin
              done <= 1'b1;
            end else begin
              sel    <= req_sel;
              stateR <= SETTLE;
              cntR   <= SETTLE_LOAD;
            end
          end else begin
            cntR <= cntR;
          end
        end
        SETTLE: begin
          if (cntR == '0) begin
            cur_sel <= sel;
            done    <= 1'b1;
            if (switch_count != COUNT_MAX) begin
              switch_count <= switch_count + COUNT_W'(1);
            end else begin
              switch_count <= switch_count;
            end
            // A zero holdoff lets the next request in straight after the commit.
            if (HOLDOFF_CYCLES == 0) begin
              stateR <= IDLE;
            end else begin
              stateR <= HOLDOFF;
              cntR   <= HOLDOFF_LOAD;
            end
          end else begin
            cntR <= cntR - CW'(1);
          end
        end
        HOLDOFF: begin
          if (cntR == '0) begin
            stateR <= IDLE;
          end else begin
            cntR <= cntR - CW'(1);
          end
        end
        default: begin
          stateR <= IDLE;
          cntR   <= '0;
        end
      endcase
    end
  end

endmodule
